// File: rtl/coin_pulse_gen.sv
// Coin-sensor front end: synchronizes and debounces two raw coin switches and
// emits clean, mutually exclusive single-cycle rs5/rs10 pulses separated by an idle gap.
module coin_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    output logic       rs5,
    output logic       rs10,
    output logic       pending,
    output logic       overflow,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Channel index 0 is Rs5, index 1 is Rs10.
    logic [1:0]    sync1, sync2, deb, detect;
    logic [CW-1:0] cnt [2];

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pend5, pend10, pend5_d, pend10_d;
    logic          rs5_d, rs10_d, overflow_d, launch_ok;

    assign dbg_state = state_q;

    // Synchronizer and debounce counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1 <= {coin10_raw, coin5_raw};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // A detect is the edge on which deb is about to flip from 0 to 1.
    always_comb begin
        detect = '0;
        for (int i = 0; i < 2; i++)
            detect[i] = sync2[i] && !deb[i] && (cnt[i] == DEB_LAST);
    end

    // State register (also holds the registered outputs and pending flags)
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            pend5    <= 1'b0;
            pend10   <= 1'b0;
            rs5      <= 1'b0;
            rs10     <= 1'b0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            pend5    <= pend5_d;
            pend10   <= pend10_d;
            rs5      <= rs5_d;
            rs10     <= rs10_d;
            pending  <= pend5_d | pend10_d;
            overflow <= overflow_d;
        end
    end

    // Next-state logic; an expired gap may launch the next pulse directly.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (pend10 || pend5) state_d = PULSE;
            end
            PULSE: begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
            end
            GAP: begin
                if (gap_q == '0) state_d = (pend10 || pend5) ? PULSE : IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: pulse selection, pending flags and sticky overflow
    always_comb begin
        launch_ok  = (state_q == IDLE) || ((state_q == GAP) && (gap_q == '0));
        rs10_d     = launch_ok && pend10;
        rs5_d      = launch_ok && !pend10 && pend5;
        pend5_d    = detect[0] | (pend5 & ~rs5_d);
        pend10_d   = detect[1] | (pend10 & ~rs10_d);
        overflow_d = overflow
                   | (detect[0] & pend5 & ~rs5_d)
                   | (detect[1] & pend10 & ~rs10_d);
    end

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Directed bench for coin_pulse_gen: one instance with a short gap for most
// scenarios and one with a long gap to force a queue overflow.
module tb_coin_pulse_gen;

    localparam int GA = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin5_raw = 1'b0;
    logic       coin10_raw = 1'b0;
    logic       rs5, rs10, pending, overflow;
    logic [1:0] dbg_state;
    logic       b_rs5, b_rs10, b_pending, b_overflow;
    logic [1:0] b_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // per-scenario trackers, indexed by edge number (E0 = first edge of scenario)
    int cyc, n5, n10, first5, first10, pf, pl, nb5, lastb5, fob;

    always #5 clk = ~clk;

    coin_pulse_gen #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(GA)) dut_a (
        .clk(clk), .reset(reset), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
        .rs5(rs5), .rs10(rs10), .pending(pending), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    coin_pulse_gen #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(30)) dut_b (
        .clk(clk), .reset(reset), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
        .rs5(b_rs5), .rs10(b_rs10), .pending(b_pending), .overflow(b_overflow),
        .dbg_state(b_dbg_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output invariants on instance A: exclusivity, one-cycle pulses, min gap
    int   viol = 0;
    int   lowrun = 0;
    bit   seen = 0;
    logic p5 = 1'b0, p10 = 1'b0;
    always @(negedge clk) begin
        if (rs5 && rs10) viol++;
        if ((rs5 && p5) || (rs10 && p10)) viol++;
        if (rs5 || rs10) begin
            if (seen && lowrun < GA) viol++;
            seen   = 1;
            lowrun = 0;
        end else begin
            lowrun++;
        end
        p5  = rs5;
        p10 = rs10;
        if (!reset) seen = 0;
    end

    task clear_trk();
        cyc = -1; n5 = 0; n10 = 0; first5 = -1; first10 = -1;
        pf = -1; pl = -1; nb5 = 0; lastb5 = -1; fob = -1;
    endtask

    task step(input logic c5, input logic c10);
        coin5_raw  = c5;
        coin10_raw = c10;
        @(posedge clk);
        #1;
        cyc++;
        if (rs5)  begin n5++;  if (first5 < 0)  first5 = cyc;  end
        if (rs10) begin n10++; if (first10 < 0) first10 = cyc; end
        if (pending) begin if (pf < 0) pf = cyc; pl = cyc; end
        if (b_rs5) begin nb5++; lastb5 = cyc; end
        if (b_overflow && fob < 0) fob = cyc;
    endtask

    task do_reset(input int n);
        reset      = 1'b0;
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset(2);
        check("rst_rs5", rs5, 0);
        check("rst_rs10", rs10, 0);
        check("rst_pending", pending, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", dbg_state, 0);

        // single clean coin
        clear_trk();
        repeat (10) step(1, 0);
        repeat (12) step(0, 0);
        check("single_n5", n5, 1);
        check("single_at", first5, 6);
        check("single_n10", n10, 0);
        check("single_pend_first", pf, 5);
        check("single_pend_last", pl, 5);
        check("single_ovf", overflow, 0);

        // bounce rejection: first stable sample is E12
        do_reset(2);
        clear_trk();
        for (int i = 0; i < 12; i++) step(0, ((i / 2) % 2) == 0);
        repeat (15) step(0, 1);
        repeat (12) step(0, 0);
        check("bounce_n10", n10, 1);
        check("bounce_at", first10, 18);
        check("bounce_n5", n5, 0);

        // simultaneous coins: rs10 first, rs5 after the gap
        do_reset(2);
        clear_trk();
        repeat (10) step(1, 1);
        repeat (12) step(0, 0);
        check("simul_rs10_at", first10, 6);
        check("simul_rs5_at", first5, 9);
        check("simul_n", n5 + n10, 2);
        check("simul_pend_last", pl, 8);

        // overflow: detects at E5, E17, E29; long-gap instance relaunches at E37
        do_reset(2);
        clear_trk();
        repeat (3) begin
            repeat (6) step(1, 0);
            repeat (6) step(0, 0);
        end
        repeat (34) step(0, 0);
        check("ovf_b_n5", nb5, 2);
        check("ovf_b_second_at", lastb5, 37);
        check("ovf_b_set_at", fob, 29);
        check("ovf_b_sticky", b_overflow, 1);
        check("ovf_a_n5", n5, 3);
        check("ovf_a_clear", overflow, 0);

        // reset mid-gap with Rs5 queued
        do_reset(2);
        clear_trk();
        repeat (8) step(1, 1);
        check("midgap_rs10_issued", n10, 1);
        check("midgap_queued", pending, 1);
        reset = 1'b0;
        step(0, 0);
        check("midgap_outs", {rs5, rs10, pending, overflow}, 0);
        check("midgap_state", dbg_state, 0);
        reset = 1'b1;
        repeat (15) step(0, 0);
        check("midgap_no_rs5", n5, 0);

        // short glitch
        do_reset(2);
        clear_trk();
        repeat (3) step(1, 0);
        repeat (15) step(0, 0);
        check("glitch_n5", n5, 0);
        check("glitch_pending", pf, -1);
        check("glitch_ovf", overflow, 0);

        // coin held high through reset counts once after release
        reset     = 1'b0;
        coin5_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_trk();
        repeat (12) step(1, 0);
        repeat (12) step(0, 0);
        check("held_n5", n5, 1);
        check("held_at", first5, 6);

        check("invariants", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
